// File: rtl/button_event_scheduler_pkg.sv
// rtl/button_event_scheduler_pkg.sv - shared constants and helpers for the button event scheduler
// Purpose: button index values decoded by the counter FSM, default sizes, round-robin helper.
// Ports: none (package).
package button_event_scheduler_pkg;

    localparam int N_BTN_DEF      = 4;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int DROP_W_DEF     = 8;

    localparam int BTN_START = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_CLR   = 2;
    localparam int BTN_MODE  = 3;

    // Candidate index k steps after base, wrapped into 0..n-1 (k in 1..n).
    function automatic int rr_next(input int base, input int k, input int n);
        int j;
        j = base + k;
        if (j >= n) j = j - n;
        return j;
    endfunction

endpackage

// File: rtl/button_event_scheduler_if.sv
// rtl/button_event_scheduler_if.sv - valid/ready command port between scheduler and counter core
// Purpose: carries one button-index command per handshake.
// Signals: cmd_valid_o (head valid), cmd_idx_o (head index), cmd_ready_i (consumer accepts).
// Modports: master = scheduler side, slave = counter core side.
interface button_event_scheduler_if #(
    parameter int IDX_W = 2
);
    logic             cmd_valid_o;
    logic [IDX_W-1:0] cmd_idx_o;
    logic             cmd_ready_i;

    modport master (output cmd_valid_o, output cmd_idx_o, input  cmd_ready_i);
    modport slave  (input  cmd_valid_o, input  cmd_idx_o, output cmd_ready_i);
endinterface

// File: rtl/button_event_scheduler_fifo.sv
// rtl/button_event_scheduler_fifo.sv - command queue for the button event scheduler
// Purpose: small register FIFO with registered pointers and occupancy count.
// Ports: clk, rst (async active-high), i_push/i_wdata write side, i_pop read side,
//        o_rdata = entry at read pointer, o_count = occupancy.
module sched_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    // Storage is reset too so the head index reads as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/button_event_scheduler.sv
// rtl/button_event_scheduler.sv - round-robin scheduler from debounced button pulses to counter commands
// Purpose: latch press pulses as pending bits, grant one per cycle round-robin into a
//          command FIFO, and present the FIFO head on a valid/ready command port.
// Ports: clk_core, rst (async active-high), btn_pulse_i (one-cycle presses),
//        cmd (master modport: cmd_valid_o/cmd_idx_o/cmd_ready_i),
//        busy_o (work pending or queued), drop_cnt_o (saturating lost-press count).
module button_event_scheduler
    import button_event_scheduler_pkg::*;
#(
    parameter int N_BTN      = N_BTN_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int IDX_W      = $clog2(N_BTN),
    parameter int DROP_W     = DROP_W_DEF
) (
    input  logic                          clk_core,
    input  logic                          rst,
    input  logic [N_BTN-1:0]              btn_pulse_i,
    button_event_scheduler_if.master      cmd,
    output logic                          busy_o,
    output logic [DROP_W-1:0]             drop_cnt_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [N_BTN-1:0]  r_pend;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [DROP_W-1:0] r_drop_cnt;

    logic [CW-1:0]     w_count;
    logic [IDX_W-1:0]  w_rdata;
    logic [IDX_W-1:0]  w_cand;
    logic [IDX_W-1:0]  w_gidx;
    logic              w_found;
    logic              w_grant;
    logic              w_pop;
    logic [N_BTN-1:0]  w_gmask;
    logic [N_BTN-1:0]  w_drop;
    logic [3:0]        w_ndrop;
    logic [DROP_W+3:0] w_drop_sum;

    // Search starts one past the last winner and wraps, first pending bit wins.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_cand  = '0;
        for (int k = 1; k <= N_BTN; k++) begin
            w_cand = IDX_W'(rr_next(int'(r_rr_ptr), k, N_BTN));
            if (!w_found && r_pend[w_cand]) begin
                w_found = 1'b1;
                w_gidx  = w_cand;
            end
        end
    end

    // The full check uses the registered count, so a same-cycle pop never frees a slot.
    assign w_grant = w_found && (w_count < CW'(FIFO_DEPTH));
    assign w_gmask = w_grant ? (N_BTN'(1) << w_gidx) : '0;

    // A press is lost only when its bit is already pending and not being granted now.
    assign w_drop  = btn_pulse_i & r_pend & ~w_gmask;

    always_comb begin
        w_ndrop = '0;
        for (int i = 0; i < N_BTN; i++) w_ndrop = w_ndrop + {3'b000, w_drop[i]};
    end

    assign w_drop_sum = {4'b0000, r_drop_cnt} + {{DROP_W{1'b0}}, w_ndrop};

    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            r_pend     <= '0;
            r_rr_ptr   <= IDX_W'(N_BTN - 1);
            r_drop_cnt <= '0;
        end else begin
            r_pend <= (r_pend & ~w_gmask) | btn_pulse_i;
            if (w_grant) r_rr_ptr <= w_gidx;
            if (w_drop_sum[DROP_W+3:DROP_W] != 4'b0000) r_drop_cnt <= '1;
            else                                        r_drop_cnt <= w_drop_sum[DROP_W-1:0];
        end
    end

    sched_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (IDX_W)
    ) u_fifo (
        .clk     (clk_core),
        .rst     (rst),
        .i_push  (w_grant),
        .i_wdata (w_gidx),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_count (w_count)
    );

    assign cmd.cmd_valid_o = (w_count != '0);
    assign cmd.cmd_idx_o   = w_rdata;
    assign w_pop           = cmd.cmd_valid_o && cmd.cmd_ready_i;
    assign busy_o          = (|r_pend) || (w_count != '0);
    assign drop_cnt_o      = r_drop_cnt;

endmodule

// File: tb/tb_button_event_scheduler.sv
// tb/tb_button_event_scheduler.sv - scoreboard bench for the button event scheduler
module tb_button_event_scheduler;
    import button_event_scheduler_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] pulse = '0;
    logic       busy;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    button_event_scheduler_if #(.IDX_W(2)) cmd_if();

    button_event_scheduler #(
        .N_BTN(4), .FIFO_DEPTH(4), .IDX_W(2), .DROP_W(8)
    ) dut (
        .clk_core    (clk),
        .rst         (rst),
        .btn_pulse_i (pulse),
        .cmd         (cmd_if),
        .busy_o      (busy),
        .drop_cnt_o  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted command and checks handshake stability.
    logic       prev_v = 1'b0;
    logic       prev_r = 1'b0;
    logic [1:0] prev_idx = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
            prev_r = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                chk("hold_valid", int'(cmd_if.cmd_valid_o), 1);
                chk("hold_idx", int'(cmd_if.cmd_idx_o), int'(prev_idx));
            end
            if (cmd_if.cmd_valid_o && cmd_if.cmd_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_cmd actual idx=%0d required none", cmd_if.cmd_idx_o);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("cmd_idx", int'(cmd_if.cmd_idx_o), e);
                end
            end
            prev_v   = cmd_if.cmd_valid_o;
            prev_r   = cmd_if.cmd_ready_i;
            prev_idx = cmd_if.cmd_idx_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] m);
        pulse = m;
        tick();
        pulse = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pulse = '0;
        cmd_if.cmd_ready_i = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            tick();
            t++;
        end
        chk(nm, exp_q.size(), 0);
        tick();
    endtask

    initial begin
        cmd_if.cmd_ready_i = 1'b0;

        // 1: reset state and single press
        do_reset();
        chk("rst_valid", int'(cmd_if.cmd_valid_o), 0);
        chk("rst_idx", int'(cmd_if.cmd_idx_o), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        cmd_if.cmd_ready_i = 1'b1;
        exp_q.push_back(BTN_START);
        press(4'b0001);
        chk("t1_valid_e1", int'(cmd_if.cmd_valid_o), 0);
        chk("t1_busy_e1", int'(busy), 1);
        tick();
        chk("t1_valid_e2", int'(cmd_if.cmd_valid_o), 1);
        chk("t1_idx_e2", int'(cmd_if.cmd_idx_o), 0);
        tick();
        chk("t1_valid_e3", int'(cmd_if.cmd_valid_o), 0);
        chk("t1_busy_e3", int'(busy), 0);
        chk("t1_drained", exp_q.size(), 0);

        // 2: simultaneous presses after reset
        do_reset();
        cmd_if.cmd_ready_i = 1'b1;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        press(4'b1111);
        wait_drain("t2_drained");
        chk("t2_drop", int'(drop_cnt), 0);
        chk("t2_busy", int'(busy), 0);

        // 3: round-robin fairness with rr_ptr=1
        do_reset();
        cmd_if.cmd_ready_i = 1'b1;
        exp_q.push_back(1);
        press(4'b0010);
        wait_drain("t3a_drained");
        exp_q.push_back(3); exp_q.push_back(1);
        press(4'b1010);
        wait_drain("t3b_drained");

        // 4: backpressure with six presses
        do_reset();
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(1);
        press(4'b0001); press(4'b0010); press(4'b0100);
        press(4'b1000); press(4'b0001); press(4'b0010);
        repeat (4) tick();
        chk("t4_valid", int'(cmd_if.cmd_valid_o), 1);
        chk("t4_head", int'(cmd_if.cmd_idx_o), 0);
        chk("t4_busy", int'(busy), 1);
        cmd_if.cmd_ready_i = 1'b1;
        wait_drain("t4_drained");
        chk("t4_drop", int'(drop_cnt), 0);
        chk("t4_busy_end", int'(busy), 0);

        // 5a: drop counter saturation while full
        do_reset();
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(2);
        press(4'b0001); press(4'b0010); press(4'b0100); press(4'b1000);
        repeat (300) press(4'b0100);
        tick();
        chk("t5_drop_sat", int'(drop_cnt), 255);
        chk("t5_busy", int'(busy), 1);
        cmd_if.cmd_ready_i = 1'b1;
        wait_drain("t5a_drained");
        chk("t5_drop_hold", int'(drop_cnt), 255);

        // 5b: re-pulse on the grant cycle is a new event, not a drop
        do_reset();
        exp_q.push_back(2); exp_q.push_back(2);
        press(4'b0100);
        press(4'b0100);
        tick();
        chk("t5b_drop", int'(drop_cnt), 0);
        chk("t5b_valid", int'(cmd_if.cmd_valid_o), 1);
        cmd_if.cmd_ready_i = 1'b1;
        wait_drain("t5b_drained");
        chk("t5b_drop_end", int'(drop_cnt), 0);

        // 6: async reset mid-stall
        do_reset();
        press(4'b1000);
        press(4'b0010);
        tick();
        chk("t6_valid_pre", int'(cmd_if.cmd_valid_o), 1);
        chk("t6_idx_pre", int'(cmd_if.cmd_idx_o), 3);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_valid_async", int'(cmd_if.cmd_valid_o), 0);
        chk("t6_idx_async", int'(cmd_if.cmd_idx_o), 0);
        chk("t6_busy_async", int'(busy), 0);
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        cmd_if.cmd_ready_i = 1'b1;
        exp_q.push_back(0); exp_q.push_back(2);
        press(4'b0101);
        wait_drain("t6_drained");
        chk("t6_drop", int'(drop_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
